// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO: issues rd_en, absorbs the one-cycle
// read latency and re-presents the words as a valid/ready stream via a 3-entry skid buffer.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] pop_count
);

  logic [WIDTH-1:0] mem [0:2];
  logic [1:0]       head, tail, occ;
  logic             inflight;
  logic [2:0]       pend;
  logic             cap, pop;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Held words plus the one in flight must leave room for the word being issued,
  // so issue never looks at m_ready.
  assign pend       = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = rst_n && !fifo_empty && (pend < 3'd3);

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[head];
  assign cap     = inflight;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      pop_count <= '0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (cap) begin
        mem[tail] <= fifo_rd_data;
        tail      <= nxt(tail);
      end
      if (pop) begin
        head      <= nxt(head);
        pop_count <= pop_count + 1'b1;
      end
      case ({cap, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the team's synchronous FIFO. Drives the FIFO's `rd_en` and handles the FIFO's one-cycle registered read latency. Re-presents the popped words as a valid/ready stream, with a 3-entry skid buffer so that downstream backpressure never drops or duplicates a word. Sits directly on the FIFO's read port, feeding any consumer block that uses valid/ready handshakes.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO's `width`.
- `CNT_W`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd_en`  out  1  FIFO `rd_en`; a pop is requested this cycle.
- `fifo_rd_data`  in  WIDTH  FIFO `rd_data`. Registered in the FIFO; valid in the cycle after an accepted `rd_en`, and holds its value otherwise.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  WIDTH  output word.
- `pop_count`  out  CNT_W  number of words delivered (`m_valid && m_ready`); wraps modulo 2^CNT_W.

## Operation
**Internal state**
- 3-entry circular buffer (`buf[0..2]`) with 2-bit head and tail pointers.
- `occ`: number of held words, 0..3.
- `inflight`: 1-bit, the registered copy of `fifo_rd_en`.

**Issue rule**
- `fifo_rd_en = rst_n && !fifo_empty && (occ + inflight) < 3`.
- Depends only on registers and `fifo_empty`; there is no combinational path from `m_ready`.
- Because issue requires `!fifo_empty`, every issued read is accepted by the FIFO.

**Capture**
- When `inflight == 1`, `fifo_rd_data` is written to `buf[tail]` and tail advances (wraps 2 -> 0).

**Output**
- `m_valid = (occ != 0)`.
- `m_data = buf[head]`.

**Pop**
- When `m_valid && m_ready`, head advances (wraps 2 -> 0) and `pop_count` increments.

**Occupancy update**
- `occ_next = occ + capture - pop`.
- Capture and pop in the same cycle leave `occ` unchanged. Both still happen: tail and head each advance.

**Guarantees**
- Ordering is strict FIFO order.
- No word is lost, duplicated, or reordered under any `m_ready` pattern.
- `occ + inflight <= 3` always, so the buffer never overflows.

**Reset**
- Asynchronous assertion clears `occ`, `inflight`, head, tail, and `pop_count`.
- Buffer contents are don't-care, but `m_data` reads 0 at reset: clear `buf[0]`.
- A word in flight when reset asserts is discarded. The FIFO must be reset by the same `rst_n` event so that both ends restart empty.

## Timing
**Reset values**
- `fifo_rd_en = 0`, `m_valid = 0`, `m_data = 0`, `pop_count = 0`.

**Latency**
- With `fifo_rd_en` high in cycle T, the FIFO registers data at the end of T and `inflight = 1` in T+1.
- The word is captured at the end of T+1, so `m_valid = 1` in T+2.
- Minimum latency from `fifo_empty` low to `m_valid` high is 2 cycles.

**Throughput**
- With `m_ready` held high and the FIFO non-empty, steady state is `occ = 1`, `inflight = 1`.
- This gives one word per cycle, with `fifo_rd_en` high every cycle.

**Backpressure**
- With `m_ready` low, at most 3 more words are popped from the FIFO, then `fifo_rd_en` stays low.

**Handshake rules**
- While `m_valid && !m_ready`, `m_valid` stays high and `m_data` is held stable.
- `m_valid` never drops without a pop.

**Empty FIFO**
- While `fifo_empty` is high, `fifo_rd_en` is low.
- Buffered words continue to drain downstream.

## Test plan
- **Reset:** hold `rst_n = 0` for 3 cycles with the FIFO pre-loaded -> `fifo_rd_en`, `m_valid`, `m_data`, and `pop_count` all 0. After release, the first `m_valid` appears exactly 2 cycles after the first `fifo_rd_en`.
- **Streaming:** write 0x01..0x08 to an 8-deep FIFO, `m_ready = 1` -> 8 consecutive `m_valid` cycles carrying 0x01..0x08 in order; `pop_count = 8`; `fifo_rd_en` high for 8 consecutive cycles.
- **Backpressure:** FIFO holds 0x10..0x15, `m_ready = 0` -> exactly 3 `fifo_rd_en` pulses, `m_data` stable at 0x10, `occ = 3`. Releasing `m_ready` delivers 0x10..0x15 in order with no gaps after the first.
- **Random ready:** 200 random words with `m_ready` random at 50% -> output sequence matches input exactly, and `m_data` never changes while `m_valid && !m_ready`.
- **Simultaneous capture/pop and wrap:** keep `occ = 1` with both capture and pop every cycle for 10 cycles -> head and tail wrap 2->0 at least 3 times; data stays in order.
- **Mid-operation reset and counter wrap:** assert `rst_n` low while `inflight = 1` and `occ = 2` -> outputs clear immediately, with no stale word after release. Separately, with `CNT_W = 4`, deliver 17 words -> `pop_count = 1`.
